fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the 8-bit CPU. Owns the program counter and drives the combinational program ROM's line-number input. Latches the returned instruction byte into an instruction register for the execute stage. Resolves JMP/JNZ in the cycle the jump occupies the instruction register, squashing the wrong-path fetch, and supports a stall from downstream.

## Interface
- PC_WIDTH, 8, program counter width; matches the ROM line-number width.
- NOP_WORD, 8'h00, instruction byte injected on reset and on squash.
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- instr_in  input  8  instruction byte from the program ROM at address pc_out (combinational, same cycle).
- zero_flag  input  1  ALU zero flag; reflects the most recently completed CMP/ADD/INC.
- stall  input  1  execute stage not ready; hold all state.
- pc_out  output  PC_WIDTH  current fetch address; drives the ROM line number.
- ir_out  output  8  instruction register; consumed by execute.
- ir_valid  output  1  ir_out holds a real fetched instruction (not reset or squash filler).
- branch_taken  output  1  one-cycle pulse on the edge where a jump redirects the PC.

## Operation
- Encoding: opcode = instr[7:4]; jump target = instr[3:0], zero-extended to PC_WIDTH.
- Jump opcodes: JMP = 4'b1100 (unconditional); JNZ = 4'b1011 (taken when zero_flag == 0). All other opcodes are sequential.
- Reset: pc_out = 0, ir_out = NOP_WORD, ir_valid = 0, branch_taken = 0.
- Per edge, with rst = 0, priority is stall > taken jump > sequential:
  - stall = 1: pc_out, ir_out and ir_valid hold. branch_taken = 0. The jump decision is deferred; it is re-evaluated with the then-current zero_flag when stall drops.
  - ir_valid = 1 and ir_out is a taken jump: pc_out <= target, ir_out <= NOP_WORD, ir_valid <= 0, branch_taken <= 1. The byte at the old pc_out is discarded.
  - Otherwise: ir_out <= instr_in, ir_valid <= 1, pc_out <= pc_out + 1, branch_taken <= 0.
- A not-taken JNZ behaves as sequential.
- A jump in ir_out with ir_valid = 0 is never acted on. This cannot occur, because squash loads NOP_WORD.
- Wrap-around: pc_out = 2^PC_WIDTH−1 increments to 0; no error is flagged.
- A jump to its own address forms a legal infinite loop: squash, refetch, squash, and so on.
- Reset asserted mid-operation (including during stall or a branch cycle) overrides everything on that edge.

## Timing
- ROM path is combinational: instr_in must be valid within the cycle pc_out is presented.
- Fetch latency is 1 cycle: the byte at address A appears on ir_out on the edge after pc_out = A.
- Taken-branch penalty is 1 bubble cycle (ir_valid = 0).
- The target instruction reaches ir_out 2 edges after the jump entered ir_out.
- First valid instruction appears on the first edge after rst deasserts: ir_out = ROM[0], pc_out = 1.
- zero_flag is sampled in the cycle the jump sits in ir_out with stall = 0.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package cpu_pkg holds:
  - opcode constants OP_NOP 4'b0000, OP_ADD 4'b0001, OP_INC 4'b0111, OP_MOV 4'b1000, OP_CMP 4'b1001, OP_JNZ 4'b1011, OP_JMP 4'b1100;
  - field-slice helpers (opcode, target);
  - NOP_WORD.
- One combinational sub-module, branch_resolve: inputs ir, ir_valid, zero_flag; outputs take and target. fetch_unit holds the PC/IR registers and the priority mux.

## Test plan
- Reset then free-run with ROM = 00,8F,8B,85: ir_out sequence 00,8F,8B,85; pc_out 1,2,3,4; ir_valid 0 then 1.
- JMP: ROM[9] = C1. Edge after ir_out = C1 gives pc_out = 1, ir_out = 00, ir_valid = 0, branch_taken = 1; next edge gives ir_out = ROM[1], pc_out = 2.
- JNZ: ir_out = B5. With zero_flag = 0, pc_out becomes 5 and there is a bubble. With zero_flag = 1, pc_out increments normally, no bubble, branch_taken = 0.
- Stall for 3 cycles while ir_out = B5 and zero_flag = 0: all outputs frozen; on release, redirect to 5 occurs on the first edge.
- Wrap: force sequential fetch to pc_out = 255, then next edge gives pc_out = 0 and ir_out = ROM[255].
- rst pulsed in the cycle branch_taken would fire: pc_out = 0, ir_out = 00, ir_valid = 0, branch_taken = 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU.
// Opcodes, filler word and instruction field helpers.
package cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_INC = 4'b0111;
  localparam logic [3:0] OP_MOV = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1001;
  localparam logic [3:0] OP_JNZ = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;

  localparam logic [7:0] NOP_WORD = 8'h00;

  function automatic logic [3:0] op_of(
    input logic [7:0] instr
  );
    return instr[7:4];
  endfunction

  function automatic logic [3:0] tgt_of(
    input logic [7:0] instr
  );
    return instr[3:0];
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// Jump decision for the instruction register.
// Pure combinational: take flag and redirect target.
module branch_resolve #(
  parameter int PC_WIDTH = 8
) (
  input  logic [7:0]          ir,
  input  logic                ir_valid,
  input  logic                zero_flag,
  output logic                take,
  output logic [PC_WIDTH-1:0] target
);
  import cpu_pkg::*;

  logic is_jmp;
  logic is_jnz;

  assign is_jmp = (op_of(ir) == OP_JMP);
  assign is_jnz = (op_of(ir) == OP_JNZ);
  assign target = PC_WIDTH'(tgt_of(ir));

  // Only a real fetched jump may redirect the PC.
  always_comb begin
    take = 1'b0;
    unique case (1'b1)
      is_jmp:  take = ir_valid;
      is_jnz:  take = ir_valid & ~zero_flag;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, IR and jump squash.
// Priority per edge: reset > stall > taken jump > sequential.
module fetch_unit #(
  parameter int         PC_WIDTH = 8,
  parameter logic [7:0] NOP_WORD = cpu_pkg::NOP_WORD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          instr_in,
  input  logic                zero_flag,
  input  logic                stall,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic [7:0]          ir_out,
  output logic                ir_valid,
  output logic                branch_taken
);

  logic                take;
  logic [PC_WIDTH-1:0] target;

  branch_resolve #(
    .PC_WIDTH (PC_WIDTH)
  ) u_br (
    .ir        (ir_out),
    .ir_valid  (ir_valid),
    .zero_flag (zero_flag),
    .take      (take),
    .target    (target)
  );

  // PC/IR update: hold on stall, squash on jump, else fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out       <= '0;
      ir_out       <= NOP_WORD;
      ir_valid     <= 1'b0;
      branch_taken <= 1'b0;
    end else if (stall) begin
      branch_taken <= 1'b0;
    end else if (take) begin
      pc_out       <= target;
      ir_out       <= NOP_WORD;
      ir_valid     <= 1'b0;
      branch_taken <= 1'b1;
    end else begin
      pc_out       <= pc_out + 1'b1;
      ir_out       <= instr_in;
      ir_valid     <= 1'b1;
      branch_taken <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed plan plus random run.
// Reference model tracks pc/ir/valid/taken per edge.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stall = 1'b0;
  logic       zero_flag = 1'b0;
  logic [7:0] instr_in;
  logic [7:0] pc_out;
  logic [7:0] ir_out;
  logic       ir_valid;
  logic       branch_taken;

  logic [7:0] rom [256];

  int n_chk = 0;
  int n_pass = 0;

  int         m_pc;
  logic [7:0] m_ir;
  logic       m_v;
  logic       m_bt;

  always #5 clk = ~clk;

  assign instr_in = rom[pc_out];

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .instr_in     (instr_in),
    .zero_flag    (zero_flag),
    .stall        (stall),
    .pc_out       (pc_out),
    .ir_out       (ir_out),
    .ir_valid     (ir_valid),
    .branch_taken (branch_taken)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Reference: next state from the architectural rules.
  task automatic model_edge(
    input logic r,
    input logic s,
    input logic z
  );
    int  op;
    bit  jump;
    op = int'(m_ir) / 16;
    jump = m_v && (op == 12 || (op == 11 && !z));
    if (r) begin
      m_pc = 0; m_ir = 8'h00; m_v = 0; m_bt = 0;
    end else if (s) begin
      m_bt = 0;
    end else if (jump) begin
      m_pc = int'(m_ir) % 16;
      m_ir = 8'h00; m_v = 0; m_bt = 1;
    end else begin
      m_ir = rom[m_pc];
      m_v = 1;
      m_pc = (m_pc + 1) % 256;
      m_bt = 0;
    end
  endtask

  task automatic step(
    input logic r,
    input logic s,
    input logic z
  );
    @(negedge clk);
    rst = r; stall = s; zero_flag = z;
    @(posedge clk);
    model_edge(r, s, z);
    #1;
    chk("pc", 32'(pc_out), 32'(m_pc));
    chk("ir", 32'(ir_out), 32'(m_ir));
    chk("vld", 32'(ir_valid), 32'(m_v));
    chk("bt", 32'(branch_taken), 32'(m_bt));
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] seq [4];
    m_pc = 0; m_ir = 8'h00; m_v = 0; m_bt = 0;
    clear_rom();

    // Free-run from reset.
    seq[0] = 8'h00; seq[1] = 8'h8F;
    seq[2] = 8'h8B; seq[3] = 8'h85;
    for (int i = 0; i < 4; i++) rom[i] = seq[i];
    do_reset();
    chk("rst_pc", 32'(pc_out), 0);
    chk("rst_ir", 32'(ir_out), 0);
    chk("rst_vld", 32'(ir_valid), 0);
    chk("rst_bt", 32'(branch_taken), 0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0);
      chk("seq_ir", 32'(ir_out), 32'(seq[i]));
      chk("seq_pc", 32'(pc_out), i + 1);
      chk("seq_vld", 32'(ir_valid), 1);
    end

    // JMP at address 9 to 1.
    clear_rom();
    rom[1] = 8'h8F;
    rom[9] = 8'hC1;
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
    chk("jmp_in_ir", 32'(ir_out), 32'h C1);
    step(1'b0, 1'b0, 1'b0);
    chk("jmp_pc", 32'(pc_out), 1);
    chk("jmp_ir", 32'(ir_out), 0);
    chk("jmp_vld", 32'(ir_valid), 0);
    chk("jmp_bt", 32'(branch_taken), 1);
    step(1'b0, 1'b0, 1'b0);
    chk("jmp_tgt_ir", 32'(ir_out), 32'h8F);
    chk("jmp_tgt_pc", 32'(pc_out), 2);

    // JNZ taken.
    clear_rom();
    rom[3] = 8'hB5;
    rom[4] = 8'h84;
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("jnz_t_pc", 32'(pc_out), 5);
    chk("jnz_t_vld", 32'(ir_valid), 0);
    chk("jnz_t_bt", 32'(branch_taken), 1);

    // JNZ not taken.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("jnz_n_pc", 32'(pc_out), 5);
    chk("jnz_n_ir", 32'(ir_out), 32'h84);
    chk("jnz_n_vld", 32'(ir_valid), 1);
    chk("jnz_n_bt", 32'(branch_taken), 0);

    // Stall holding a pending JNZ.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0);
      chk("stl_pc", 32'(pc_out), 4);
      chk("stl_ir", 32'(ir_out), 32'hB5);
      chk("stl_bt", 32'(branch_taken), 0);
    end
    step(1'b0, 1'b0, 1'b0);
    chk("stl_rel_pc", 32'(pc_out), 5);
    chk("stl_rel_bt", 32'(branch_taken), 1);

    // Reset on the would-be branch edge.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("rbr_pc", 32'(pc_out), 0);
    chk("rbr_ir", 32'(ir_out), 0);
    chk("rbr_vld", 32'(ir_valid), 0);
    chk("rbr_bt", 32'(branch_taken), 0);

    // PC wrap-around.
    clear_rom();
    rom[255] = 8'h8A;
    do_reset();
    for (int i = 0; i < 255; i++) step(1'b0, 1'b0, 1'b0);
    chk("wrap_pre", 32'(pc_out), 255);
    step(1'b0, 1'b0, 1'b0);
    chk("wrap_pc", 32'(pc_out), 0);
    chk("wrap_ir", 32'(ir_out), 32'h8A);

    // Random ROM and control.
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 49) == 0),
           1'($urandom_range(0, 3) == 0),
           1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
